serial_parity_checker: RTL
==========================

Name: serial_parity_checker

Overview:
Downstream consumer of the 2-input XOR gate's output stream. Deserialises a framed serial bit stream of DATA_BITS data bits plus one parity bit, LSB first. Accumulates running XOR parity across the frame. Reports the received word, a parity-error flag and a saturating error count. Sits between the XOR datapath and the lab's display/LED logic.

Parameters:
DATA_BITS, 8, data bits per frame (2..16)
ODD_PARITY, 0, 0 = even parity (XOR of data+parity must be 0); 1 = odd (must be 1)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start pulse; honoured only in IDLE
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in sampled on this cycle when high
abort  input  1  synchronous frame abort
busy  output  1  high in DATA and PARITY states
done  output  1  one-cycle pulse: frame complete, outputs valid
data_out  output  DATA_BITS  last received word, held until next done
parity_err  output  1  parity result of last frame, held until next done
err_count  output  ERR_CNT_W  count of frames with parity_err, saturates at all-ones

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, data_out=0, parity_err=0, err_count=0; internal shift reg, bit counter, parity accumulator = 0.
- States: IDLE, DATA, PARITY, DONE. All outputs registered.
- IDLE: start=1 -> clear shift reg, counter=0, acc=0, go DATA. bit_valid ignored in IDLE. start=1 in any other state ignored.
- DATA: on bit_valid=1: shift reg[cnt] <= bit_in (LSB first), acc <= acc ^ bit_in, cnt++. When bit_valid=1 with cnt==DATA_BITS-1 -> PARITY. bit_valid=0 cycles stall; no timeout.
- PARITY: on bit_valid=1: parity_err <= (acc ^ bit_in) != ODD_PARITY; data_out <= shift reg; err_count increments if error and not saturated; go DONE.
- DONE: done=1 for exactly this one cycle; then IDLE. Latency: done high the cycle after the parity bit is sampled.
- The data_out/parity_err/err_count update is visible in the same cycle done is high.
- start in DONE is ignored. A new frame needs start in IDLE, so the minimum gap between dones is DATA_BITS+3 cycles.
- abort=1 in DATA or PARITY: return to IDLE next cycle, no done. data_out, parity_err and err_count are unchanged, and the partial frame is discarded.
- abort in IDLE or DONE has no effect; DONE still pulses.
- abort and bit_valid in the same cycle: abort wins, and the bit is dropped.
- busy = 1 exactly while the state is DATA or PARITY.
- err_count at all-ones stays at all-ones. It is cleared only by reset.
- rst_n asserted mid-frame: immediate return to reset values; the frame is lost.

Test Plan:
- Even parity, DATA_BITS=8: start, send 0xA5 LSB-first then parity 0 -> done pulse one cycle after parity bit; data_out=0xA5, parity_err=0, err_count=0.
- Same frame with parity bit 1 -> data_out=0xA5, parity_err=1, err_count=1. Next frame 0x01 with parity 1 -> parity_err=0, err_count stays 1.
- Gapped bit_valid (valid every 3rd cycle) on frame 0x3C, parity 0 -> identical result; busy held high throughout; done exactly one cycle.
- abort after 4 data bits of frame 0xFF -> busy drops next cycle, no done, data_out/parity_err/err_count unchanged. A following full frame 0x0F, parity 0 is received correctly.
- Async reset mid-frame (after 5 bits) -> all outputs 0 immediately; start ignored while rst_n low. A post-reset frame 0x80, parity 1 -> data_out=0x80, parity_err=0.
- ERR_CNT_W=2, ODD_PARITY=1: send 4 frames 0x00 with parity 0 (each an error) -> err_count 1,2,3,3 (saturates); start asserted during DONE is ignored.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Deserialises an LSB-first frame of DATA_BITS data bits plus one parity bit,
// checks running XOR parity, and keeps a saturating count of bad frames.
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_acc;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_parity_err;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic                   w_take;
  logic                   w_perr;

  // Handshake: a bit is consumed on any cycle with bit_valid high in DATA or
  // PARITY, unless abort is also high, in which case the bit is dropped.
  assign w_take = bit_valid && !abort;
  assign w_perr = ((r_acc ^ bit_in) != ODD_PARITY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DATA;
      S_DATA: begin
        if (abort)                             w_next = S_IDLE;
        else if (bit_valid && r_cnt == LAST_CNT) w_next = S_PARITY;
      end
      S_PARITY: begin
        if (abort)          w_next = S_IDLE;
        else if (bit_valid) w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_DATA) || (w_next == S_PARITY);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_acc        <= 1'b0;
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_shift[r_cnt] <= bit_in;
            r_acc          <= r_acc ^ bit_in;
            r_cnt          <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_take) begin
            r_data_out   <= r_shift;
            r_parity_err <= w_perr;
            if (w_perr && (r_err_count != '1))
              r_err_count <= r_err_count + ERR_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data_out;
  assign parity_err = r_parity_err;
  assign err_count  = r_err_count;
  assign dbg_state  = r_state;

endmodule
